// File: rtl/mips_dmem_pkg.sv
// -----------------------------------------------------------------------------
// mips_dmem_pkg
// Shared definitions for the MIPS data-memory arbiter:
//   - opcode constants for the supported load/store instructions
//   - arbiter FSM state encoding
//   - master id constants (m0 = core LSU, m1 = DMA/debug)
//   - small opcode classification helpers used at grant time
// -----------------------------------------------------------------------------
package mips_dmem_pkg;

  // Supported MIPS memory opcodes
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LL  = 6'b110000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SC  = 6'b111000;

  // Arbiter FSM: one transaction occupies IDLE -> ACCESS -> RESP
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Master ids
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // True for every opcode the arbiter understands
  function automatic logic op_is_known(input logic [5:0] op);
    logic known;
    case (op)
      OP_LW, OP_LBU, OP_LHU, OP_LL,
      OP_SW, OP_SB, OP_SH, OP_SC: known = 1'b1;
      default:                    known = 1'b0;
    endcase
    return known;
  endfunction

  // Plain stores (sc is handled separately because it may fail)
  function automatic logic op_is_store(input logic [5:0] op);
    logic st;
    case (op)
      OP_SW, OP_SB, OP_SH: st = 1'b1;
      default:             st = 1'b0;
    endcase
    return st;
  endfunction

  // Alignment check: word ops need addr[1:0]=0, half ops need addr[0]=0
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic mis;
    case (op)
      OP_LW, OP_LL, OP_SW, OP_SC: mis = (lo != 2'b00);
      OP_LHU, OP_SH:              mis = lo[0];
      default:                    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mips_dmem_lane.sv
// -----------------------------------------------------------------------------
// mips_dmem_lane
// Purely combinational byte-lane logic for the data-memory arbiter.
//   op_i        : opcode of the access in flight
//   addr_lo_i   : byte offset within the word (addr[1:0])
//   wdata_i     : raw store data from the requester
//   rdata_raw_i : word returned by the memory
//   be_o        : byte enables for stores (0 for non-stores)
//   wdata_o     : store data replicated onto the addressed lanes
//   rdata_o     : load data, byte/half selected and zero-extended
// -----------------------------------------------------------------------------
module mips_dmem_lane
  import mips_dmem_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  // Store steering: byte enables and replicated write data
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (op_i)
      OP_SW, OP_SC: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      OP_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      OP_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load extraction with zero-extension for lbu/lhu
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (op_i)
      OP_LW, OP_LL: rdata_o = rdata_raw_i;
      OP_LBU:       rdata_o = {24'h00_0000, rdata_raw_i[{addr_lo_i, 3'b000} +: 8]};
      OP_LHU:       rdata_o = addr_lo_i[1] ? {16'h0000, rdata_raw_i[31:16]}
                                           : {16'h0000, rdata_raw_i[15:0]};
      default:      rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_dmem_arbiter
// Shares a single-port word-wide data memory between the core LSU (m0) and a
// DMA/debug port (m1). Round-robin arbitration, sb/sh lane steering, lbu/lhu
// zero-extension, access checking and the LL/SC reservation live here so the
// memory itself is a plain word store.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/op/addr/wdata       request from master X, held until mX_gnt
//   mX_gnt                     one-cycle accept pulse (IDLE only, combinational)
//   mX_rvalid/rdata/err        one-cycle completion; rdata = load data or sc
//                              status, err = access rejected
//   mem_en/we/addr/be/wdata    memory strobe, write enable, word index,
//                              byte enables, lane-steered store data
//   mem_rdata                  read word, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mips_dmem_arbiter
  import mips_dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [5:0]        m0_op,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [5:0]        m1_op,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // FSM and arbitration state
  state_e              state_q, state_d;
  logic                armed_q;        // low until the first edge after reset release
  logic                last_grant_q;

  // Transaction captured at grant
  logic                master_q;
  logic [5:0]          op_q;
  logic [ADDR_W-1:0]   word_q;
  logic [1:0]          lo_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic                sc_pass_q;
  logic                mem_ok_q;       // access reaches the memory
  logic                we_q;

  // LL/SC reservation
  logic                resv_valid_q;
  logic [ADDR_W-1:0]   resv_word_q;
  logic                resv_owner_q;

  // Grant-time combinational decode
  logic                sel_s;
  logic                grant_s;
  logic [5:0]          op_sel_s;
  logic [31:0]         addr_sel_s;
  logic [DATA_W-1:0]   wdata_sel_s;
  logic [ADDR_W-1:0]   word_sel_s;
  logic                err_sel_s;
  logic                sc_pass_sel_s;
  logic                mem_ok_sel_s;
  logic                we_sel_s;

  // Response path
  logic                access_s;
  logic                resp_s;
  logic [3:0]          lane_be_s;
  logic [31:0]         lane_wdata_s;
  logic [31:0]         lane_rdata_s;
  logic [DATA_W-1:0]   resp_data_s;

  // Round-robin select: on contention the master not granted last time wins
  always_comb begin
    sel_s = MST_M0;
    if (m0_req && m1_req) begin
      sel_s = (last_grant_q == MST_M1) ? MST_M0 : MST_M1;
    end else if (m1_req) begin
      sel_s = MST_M1;
    end else begin
      sel_s = MST_M0;
    end
  end

  assign grant_s = armed_q && (state_q == ST_IDLE) && (m0_req || m1_req);
  assign m0_gnt  = grant_s && (sel_s == MST_M0);
  assign m1_gnt  = grant_s && (sel_s == MST_M1);

  assign op_sel_s    = (sel_s == MST_M1) ? m1_op    : m0_op;
  assign addr_sel_s  = (sel_s == MST_M1) ? m1_addr  : m0_addr;
  assign wdata_sel_s = (sel_s == MST_M1) ? m1_wdata : m0_wdata;
  assign word_sel_s  = addr_sel_s[ADDR_W+1:2];

  // Rejected: unknown opcode, misaligned, or beyond the memory
  assign err_sel_s = !op_is_known(op_sel_s)
                   || op_misaligned(op_sel_s, addr_sel_s[1:0])
                   || (|addr_sel_s[31:ADDR_W+2]);

  assign sc_pass_sel_s = (op_sel_s == OP_SC) && resv_valid_q
                       && (resv_word_q == word_sel_s) && (resv_owner_q == sel_s);

  // A failing sc is answered without touching memory
  assign mem_ok_sel_s = !err_sel_s && ((op_sel_s != OP_SC) || sc_pass_sel_s);
  assign we_sel_s     = mem_ok_sel_s && (op_is_store(op_sel_s) || (op_sel_s == OP_SC));

  // Next-state logic for the three-phase transaction FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = grant_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and post-reset arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Capture the granted transaction and update round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= MST_M1;
      master_q     <= MST_M0;
      op_q         <= 6'b000000;
      word_q       <= {ADDR_W{1'b0}};
      lo_q         <= 2'b00;
      wdata_q      <= {DATA_W{1'b0}};
      err_q        <= 1'b0;
      sc_pass_q    <= 1'b0;
      mem_ok_q     <= 1'b0;
      we_q         <= 1'b0;
    end else if (grant_s) begin
      last_grant_q <= sel_s;
      master_q     <= sel_s;
      op_q         <= op_sel_s;
      word_q       <= word_sel_s;
      lo_q         <= addr_sel_s[1:0];
      wdata_q      <= wdata_sel_s;
      err_q        <= err_sel_s;
      sc_pass_q    <= sc_pass_sel_s;
      mem_ok_q     <= mem_ok_sel_s;
      we_q         <= we_sel_s;
    end
  end

  // LL/SC reservation tracking; rejected accesses leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid_q <= 1'b0;
      resv_word_q  <= {ADDR_W{1'b0}};
      resv_owner_q <= MST_M0;
    end else if (grant_s && !err_sel_s) begin
      if (op_sel_s == OP_LL) begin
        resv_valid_q <= 1'b1;
        resv_word_q  <= word_sel_s;
        resv_owner_q <= sel_s;
      end else if (op_sel_s == OP_SC) begin
        resv_valid_q <= 1'b0;
      end else if (op_is_store(op_sel_s) && (word_sel_s == resv_word_q)) begin
        resv_valid_q <= 1'b0;
      end
    end
  end

  mips_dmem_lane u_lane (
    .op_i        (op_q),
    .addr_lo_i   (lo_q),
    .wdata_i     (wdata_q),
    .rdata_raw_i (mem_rdata),
    .be_o        (lane_be_s),
    .wdata_o     (lane_wdata_s),
    .rdata_o     (lane_rdata_s)
  );

  // Memory side is derived from registered state only, so an asynchronous
  // reset during ACCESS drops the strobes immediately.
  assign access_s  = (state_q == ST_ACCESS);
  assign mem_en    = access_s && mem_ok_q;
  assign mem_we    = access_s && we_q;
  assign mem_addr  = access_s ? word_q : {ADDR_W{1'b0}};
  assign mem_be    = mem_we ? lane_be_s : (mem_en ? 4'b1111 : 4'b0000);
  assign mem_wdata = mem_we ? lane_wdata_s : {DATA_W{1'b0}};

  // Response data: zero on error or plain store, sc status, else load data
  always_comb begin
    resp_data_s = {DATA_W{1'b0}};
    if (err_q) begin
      resp_data_s = {DATA_W{1'b0}};
    end else if (op_q == OP_SC) begin
      resp_data_s = {{(DATA_W-1){1'b0}}, sc_pass_q};
    end else if (op_is_store(op_q)) begin
      resp_data_s = {DATA_W{1'b0}};
    end else begin
      resp_data_s = lane_rdata_s;
    end
  end

  assign resp_s    = (state_q == ST_RESP);
  assign m0_rvalid = resp_s && (master_q == MST_M0);
  assign m1_rvalid = resp_s && (master_q == MST_M1);
  assign m0_rdata  = m0_rvalid ? resp_data_s : {DATA_W{1'b0}};
  assign m1_rdata  = m1_rvalid ? resp_data_s : {DATA_W{1'b0}};
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_arbiter
// Directed bench for mips_dmem_arbiter with a small word-store memory model.
// A vector table drives single-master transactions; hand-written sequences
// cover contention, reset during ACCESS and reset release with pending
// requests.
// -----------------------------------------------------------------------------
module tb_mips_dmem_arbiter;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LL  = 6'b110000;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SC  = 6'b111000;
  localparam logic [5:0] BAD = 6'b000000;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [5:0]  m0_op, m1_op;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic        init_mem;
  logic [31:0] mem [64];

  int n_pass;
  int n_total;

  typedef struct packed {
    logic        mst;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        we;
    logic [5:0]  maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  mips_dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled writes, registered reads
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hDEADBEEF;
      mem[3] <= 32'h12345678;
      mem[4] <= 32'h11223344;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %h required %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mst, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic req);
    if (mst == 1'b0) begin
      m0_req = req; m0_op = op; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_op = op; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  function automatic vec_t v(input logic mst, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic en, input logic we,
                             input logic [5:0] maddr, input logic [3:0] be,
                             input logic [31:0] mwdata, input logic [31:0] rdata, input logic err);
    vec_t r;
    r.mst = mst; r.op = op; r.addr = addr; r.wdata = wdata; r.en = en; r.we = we;
    r.maddr = maddr; r.be = be; r.mwdata = mwdata; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  // One isolated transaction; called at posedge+1 with the DUT in IDLE
  task automatic run_txn(input vec_t t, input string tag);
    logic [1:0] pat;
    pat = t.mst ? 2'b10 : 2'b01;
    drive(t.mst, t.op, t.addr, t.wdata, 1'b1);
    #1;
    chk({tag, "_gnt"}, {30'h0, m1_gnt, m0_gnt}, {30'h0, pat});
    tick();
    drive(t.mst, t.op, t.addr, t.wdata, 1'b0);
    chk({tag, "_gnt_access"}, {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk({tag, "_mem_en"}, {31'h0, mem_en}, {31'h0, t.en});
    chk({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, t.we});
    if (t.en) chk({tag, "_mem_addr"}, {26'h0, mem_addr}, {26'h0, t.maddr});
    if (t.we) begin
      chk({tag, "_mem_be"}, {28'h0, mem_be}, {28'h0, t.be});
      chk({tag, "_mem_wdata"}, mem_wdata, t.mwdata);
    end
    tick();
    chk({tag, "_rvalid"}, {30'h0, m1_rvalid, m0_rvalid}, {30'h0, pat});
    chk({tag, "_rdata"}, t.mst ? m1_rdata : m0_rdata, t.rdata);
    chk({tag, "_err"}, {31'h0, t.mst ? m1_err : m0_err}, {31'h0, t.err});
    tick();
    chk({tag, "_rvalid_idle"}, {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
  endtask

  initial begin
    int waited;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; init_mem = 1'b1;
    drive(1'b0, LW, 32'h0, 32'h0, 1'b0);
    drive(1'b1, LW, 32'h0, 32'h0, 1'b0);

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("reset_outputs",
        {16'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_we, mem_be, mem_addr},
        32'h0);
    chk("reset_rdata", m0_rdata | m1_rdata | mem_wdata, 32'h0);
    init_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- contention: alternate m0,m1,m0,m1 ----------------
    drive(1'b0, LW, 32'h8,  32'h0, 1'b1);
    drive(1'b1, LW, 32'h10, 32'h0, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] pat;
      pat = (k % 2 == 0) ? 2'b01 : 2'b10;
      waited = 0;
      while (!(m0_gnt || m1_gnt) && waited < 6) begin
        tick();
        waited++;
      end
      if (waited >= 6) chk($sformatf("arb%0d_gnt_timeout", k), 32'h0, 32'h1);
      chk($sformatf("arb%0d_gnt", k), {30'h0, m1_gnt, m0_gnt}, {30'h0, pat});
      tick();
      tick();
      chk($sformatf("arb%0d_rvalid", k), {30'h0, m1_rvalid, m0_rvalid}, {30'h0, pat});
      chk($sformatf("arb%0d_rdata", k), pat[0] ? m0_rdata : m1_rdata,
          pat[0] ? 32'hDEADBEEF : 32'h11223344);
      tick();
    end
    drive(1'b0, LW, 32'h0, 32'h0, 1'b0);
    drive(1'b1, LW, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    tick();

    // ---------------- vector table ----------------
    //              mst  op   addr      wdata        en we maddr be       mwdata        rdata        err
    vecs.push_back(v(0, LW,  32'h08,  32'h0,        1, 0, 6'd2, 4'b0000, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(v(0, SB,  32'h0D,  32'h000000A5, 1, 1, 6'd3, 4'b0010, 32'hA5A5A5A5, 32'h0,        0));
    vecs.push_back(v(0, LBU, 32'h0D,  32'h0,        1, 0, 6'd3, 4'b0000, 32'h0,        32'h000000A5, 0));
    vecs.push_back(v(0, LHU, 32'h0E,  32'h0,        1, 0, 6'd3, 4'b0000, 32'h0,        32'h00001234, 0));
    vecs.push_back(v(1, SH,  32'h12,  32'h0000BEEF, 1, 1, 6'd4, 4'b1100, 32'hBEEFBEEF, 32'h0,        0));
    vecs.push_back(v(1, LW,  32'h10,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'hBEEF3344, 0));
    vecs.push_back(v(0, LBU, 32'h13,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'h000000BE, 0));
    vecs.push_back(v(0, LHU, 32'h10,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'h00003344, 0));
    vecs.push_back(v(1, SB,  32'h03,  32'h12345677, 1, 1, 6'd0, 4'b1000, 32'h77777777, 32'h0,        0));
    vecs.push_back(v(0, LW,  32'h00,  32'h0,        1, 0, 6'd0, 4'b0000, 32'h0,        32'h77000000, 0));
    vecs.push_back(v(0, LW,  32'h06,  32'h0,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        1));
    vecs.push_back(v(1, SH,  32'h03,  32'h1111,     0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        1));
    vecs.push_back(v(0, LW,  32'h100, 32'h0,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        1));
    vecs.push_back(v(1, BAD, 32'h04,  32'h0,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        1));
    vecs.push_back(v(0, LL,  32'h10,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'hBEEF3344, 0));
    vecs.push_back(v(1, SW,  32'h10,  32'hCAFEF00D, 1, 1, 6'd4, 4'b1111, 32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(v(0, SC,  32'h10,  32'h00000055, 0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, LL,  32'h10,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(v(0, SC,  32'h10,  32'h0BADF00D, 1, 1, 6'd4, 4'b1111, 32'h0BADF00D, 32'h1,        0));
    vecs.push_back(v(0, LW,  32'h10,  32'h0,        1, 0, 6'd4, 4'b0000, 32'h0,        32'h0BADF00D, 0));
    vecs.push_back(v(0, SC,  32'h10,  32'h1,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(1, LL,  32'h14,  32'h0,        1, 0, 6'd5, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, SC,  32'h14,  32'h2,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(1, SC,  32'h14,  32'h5,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, LL,  32'h20,  32'h0,        1, 0, 6'd8, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, LL,  32'h24,  32'h0,        1, 0, 6'd9, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, SC,  32'h20,  32'h3,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(v(0, LL,  32'h28,  32'h0,        1, 0, 6'd10, 4'b0000, 32'h0,       32'h0,        0));
    vecs.push_back(v(0, SC,  32'h29,  32'h4,        0, 0, 6'd0, 4'b0000, 32'h0,        32'h0,        1));
    vecs.push_back(v(0, SC,  32'h28,  32'h0000ABCD, 1, 1, 6'd10, 4'b1111, 32'h0000ABCD, 32'h1,       0));
    vecs.push_back(v(0, LW,  32'h28,  32'h0,        1, 0, 6'd10, 4'b0000, 32'h0,       32'h0000ABCD, 0));
    vecs.push_back(v(0, LL,  32'h30,  32'h0,        1, 0, 6'd12, 4'b0000, 32'h0,       32'h0,        0));
    foreach (vecs[i]) run_txn(vecs[i], $sformatf("v%0d", i));

    // ---------------- reset during ACCESS of a sw ----------------
    drive(1'b0, SW, 32'h20, 32'h00000099, 1'b1);
    #1;
    chk("rst_sw_gnt", {31'h0, m0_gnt}, 32'h1);
    tick();
    chk("rst_sw_we_before", {30'h0, mem_en, mem_we}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {30'h0, mem_en, mem_we}, 32'h0);
    drive(1'b0, SC, 32'h30, 32'h00000077, 1'b1);
    drive(1'b1, LW, 32'h08, 32'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_hold%0d", c), {28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0);
    end
    chk("rst_sw_not_written", mem[8], 32'h0);

    // ---------------- release with both requests pending ----------------
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ignored", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    tick();
    chk("release_first_gnt_m0", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    drive(1'b0, SC, 32'h30, 32'h00000077, 1'b0);
    drive(1'b1, LW, 32'h08, 32'h0, 1'b0);
    chk("release_sc_no_mem", {30'h0, mem_en, mem_we}, 32'h0);
    tick();
    chk("release_sc_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("release_sc_fail", m0_rdata, 32'h0);
    chk("release_sc_err", {31'h0, m0_err}, 32'h0);
    tick();
    chk("final_idle", {28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_dmem_arbiter.md
Name: mips_dmem_arbiter

Overview:
- Shares the single-port MIPS data memory between two requesters: m0 = core load/store unit, m1 = DMA/debug port.
- Performs round-robin arbitration and byte-lane steering for sb/sh.
- Zero-extends lbu/lhu read data.
- Owns the LL/SC reservation, so the memory array stays a plain word store.
- Sits between the core MEM stage and the data memory.

Parameters:
- ADDR_W, 6, word-index width of the memory (64 words).
- DATA_W, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  access request; held stable with op/addr/wdata until gnt
- m0_op, m1_op  in  6  MIPS opcode: lw 100011, lbu 100100, lhu 100101, ll 110000, sw 101011, sb 101000, sh 101001, sc 111000
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data
- m0_gnt, m1_gnt  out  1  one-cycle accept pulse
- m0_rvalid, m1_rvalid  out  1  one-cycle completion pulse, returned for every accepted access including stores
- m0_rdata, m1_rdata  out  32  load data, or sc status (1 = success, 0 = fail)
- m0_err, m1_err  out  1  qualifies rvalid: access was rejected
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word index
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  read word, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset:
  - Asynchronous and active-low.
  - Forces state IDLE, all outputs 0, reservation invalid, last_grant = m1 (so m0 wins first).
  - Reset during ACCESS drops mem_en/mem_we immediately; the access is abandoned and no rvalid is issued.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. One transaction per 3 cycles.
- IDLE, cycle N:
  - If any req is high, assert gnt combinationally for the selected master.
  - Register master id, op, addr and wdata; go to ACCESS.
  - Arbitration: if both requesters are high, grant the one not equal to last_grant; otherwise grant the single requester.
  - last_grant updates on every grant.
- ACCESS, cycle N+1:
  - Drive mem_addr = addr[ADDR_W+1:2].
  - For loads, ll, passing sc and stores: mem_en = 1.
  - mem_we = 1 for sw, sb, sh and passing sc.
- RESP, cycle N+2: pulse the granted master's rvalid with rdata/err; go to IDLE. gnt is never asserted outside IDLE.
- Lane rules:
  - sw, sc: be = 1111.
  - sh: be = 0011 if addr[1] = 0, else 1100; wdata replicated into both halves.
  - sb: be = one-hot on addr[1:0]; wdata[7:0] replicated into all four bytes.
  - lbu: rdata = {24'b0, selected byte}.
  - lhu: rdata = {16'b0, selected half}.
  - lw, ll: rdata = full word.
- Errors (checked at grant, in IDLE):
  - Conditions: misalignment (word ops with addr[1:0] != 0; half ops with addr[0] = 1), addr[31:ADDR_W+2] != 0, or an unlisted opcode.
  - Error access: ACCESS keeps mem_en = 0; RESP gives rvalid = 1, err = 1, rdata = 0.
  - The reservation is unaffected by an error access.
- Reservation:
  - ll sets resv_valid, resv_word and resv_owner.
  - Any successful store from either master to resv_word clears it.
  - sc passes only when resv_valid, word matches and owner matches. Any sc, pass or fail, clears the reservation.
  - A failing sc performs no memory access and returns rdata = 0, err = 0.
  - A second ll overwrites the reservation.
- Simultaneous request and reset release: requests are ignored until the first edge after rst_n rises.

Decomposition:
- Package mips_dmem_pkg holds:
  - opcode localparams (OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SW, OP_SB, OP_SH, OP_SC);
  - state encoding (IDLE/ACCESS/RESP);
  - master id constants.
- One sub-module, mips_dmem_lane: combinational byte-enable/wdata steering and load extraction/zero-extension from op + addr[1:0].

Test Plan:
- Single lw: m0 lw addr 0x8 with mem word2 = 0xDEADBEEF -> gnt at N, mem_en/addr 2 at N+1, m0_rvalid, rdata 0xDEADBEEF at N+2.
- sb addr 0x0D, wdata 0x000000A5 -> mem_addr 3, be 0010, wdata 0xA5A5A5A5. Then lbu 0x0D -> rdata 0x000000A5; lhu 0x0E on word 0x12345678 -> 0x00001234.
- Both req every cycle -> grants alternate m0, m1, m0, m1, each with rvalid 2 cycles after its gnt.
- LL/SC:
  - m0 ll 0x10; m1 sw 0x10; m0 sc 0x10 -> rdata 0, no mem_we.
  - Repeat without the m1 store -> rdata 1, mem_we, be 1111.
- Errors: lw 0x6, sh 0x3 and lw 0x100 -> each err = 1, mem_en never high, rdata 0.
- Reset: assert rst_n = 0 during ACCESS of an sw -> mem_we falls asynchronously, no rvalid. After release, reservation is invalid and m0 wins the first contention.
